// File: rtl/mm_answer_judge.sv
// mm_answer_judge
//   Answer-checking back end for the mental-math game. It adds up the
//   operands shown to the player during a round. It then judges the player's
//   answer, or a timeout, against that sum and keeps a saturating score.
//   The score is also shown on a thermometer-coded LED bar.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   round_start         1-cycle pulse, begins (or restarts) a round
//   num_valid, num_in   operand strobe and operand
//   ans_valid, ans_in   player-submit strobe and answer
//   busy                high while collecting operands or awaiting the answer
//   sum_out             registered running sum (mod 2^ANS_W)
//   result_valid        1-cycle pulse per verdict
//   correct, timed_out  verdict flags, held until the next verdict
//   score, led          current score and its thermometer display
module mm_answer_judge #(
    parameter int NUM_TERMS   = 5,
    parameter int DATA_W      = 5,
    parameter int ANS_W       = 8,
    parameter int SCORE_MAX   = 7,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 round_start,
    input  logic                 num_valid,
    input  logic [DATA_W-1:0]    num_in,
    input  logic                 ans_valid,
    input  logic [ANS_W-1:0]     ans_in,
    output logic                 busy,
    output logic [ANS_W-1:0]     sum_out,
    output logic                 result_valid,
    output logic                 correct,
    output logic                 timed_out,
    output logic [3:0]           score,
    output logic [SCORE_MAX-1:0] led
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       SMAX      = 4'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ANS_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              rv_q, rv_d;
    logic              correct_q, correct_d;
    logic              to_q, to_d;
    logic [3:0]        score_q, score_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sum_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            rv_q      <= 1'b0;
            correct_q <= 1'b0;
            to_q      <= 1'b0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            rv_q      <= rv_d;
            correct_q <= correct_d;
            to_q      <= to_d;
            score_q   <= score_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        rv_d      = 1'b0;
        correct_d = correct_q;
        to_d      = to_q;
        score_d   = score_q;

        // round_start takes priority in every state. It drops a
        // coincident operand or answer and produces no verdict.
        if (round_start) begin
            state_d = S_COLLECT;
            sum_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (num_valid) begin
                        sum_d = sum_q + ANS_W'(num_in);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_TERM) begin
                            state_d = S_WAIT;
                            tmr_d   = '0;
                        end
                    end
                end
                S_WAIT: begin
                    // An answer on the last window cycle still counts as an answer.
                    if (ans_valid) begin
                        state_d   = S_IDLE;
                        rv_d      = 1'b1;
                        correct_d = (ans_in == sum_q);
                        to_d      = 1'b0;
                    end else if (tmr_q == LAST_TICK) begin
                        state_d   = S_IDLE;
                        rv_d      = 1'b1;
                        correct_d = 1'b0;
                        to_d      = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (rv_d) begin
            if (correct_d)
                score_d = (score_q == SMAX) ? score_q : score_q + 4'd1;
            else
                score_d = (score_q == 4'd0) ? score_q : score_q - 4'd1;
        end
    end

    // Outputs
    always_comb begin
        busy         = (state_q != S_IDLE);
        sum_out      = sum_q;
        result_valid = rv_q;
        correct      = correct_q;
        timed_out    = to_q;
        score        = score_q;
        for (int i = 0; i < SCORE_MAX; i++)
            led[i] = (int'(score_q) > i);
    end

endmodule

// File: tb/tb_mm_answer_judge.sv
module tb_mm_answer_judge;

    localparam int NUM_TERMS   = 5;
    localparam int DATA_W      = 5;
    localparam int ANS_W       = 8;
    localparam int SCORE_MAX   = 7;
    localparam int TIMEOUT_CYC = 100;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 round_start = 1'b0;
    logic                 num_valid = 1'b0;
    logic [DATA_W-1:0]    num_in = '0;
    logic                 ans_valid = 1'b0;
    logic [ANS_W-1:0]     ans_in = '0;
    logic                 busy;
    logic [ANS_W-1:0]     sum_out;
    logic                 result_valid;
    logic                 correct;
    logic                 timed_out;
    logic [3:0]           score;
    logic [SCORE_MAX-1:0] led;

    int checks = 0;
    int failures = 0;

    mm_answer_judge #(
        .NUM_TERMS(NUM_TERMS), .DATA_W(DATA_W), .ANS_W(ANS_W),
        .SCORE_MAX(SCORE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .round_start(round_start),
        .num_valid(num_valid), .num_in(num_in),
        .ans_valid(ans_valid), .ans_in(ans_in),
        .busy(busy), .sum_out(sum_out), .result_valid(result_valid),
        .correct(correct), .timed_out(timed_out), .score(score), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting, 2 waiting for an answer.
    // The answer window is measured in clock edges since the last operand.
    int cyc = 0;
    int m_phase, m_total, m_terms, m_entry, m_score;
    bit m_rv, m_ok, m_to;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_total <= 0; m_terms <= 0; m_entry <= 0;
            m_rv <= 0; m_ok <= 0; m_to <= 0; m_score <= 0;
        end else begin
            m_rv <= 0;
            if (round_start) begin
                m_phase <= 1; m_total <= 0; m_terms <= 0;
            end else if (m_phase == 1 && num_valid) begin
                m_total <= (m_total + int'(num_in)) % (1 << ANS_W);
                m_terms <= m_terms + 1;
                if (m_terms + 1 == NUM_TERMS) begin
                    m_phase <= 2;
                    m_entry <= cyc;
                end
            end else if (m_phase == 2 && (ans_valid || cyc - m_entry == TIMEOUT_CYC)) begin
                m_phase <= 0;
                m_rv    <= 1;
                m_ok    <= ans_valid && (int'(ans_in) == m_total);
                m_to    <= !ans_valid;
                if (ans_valid && int'(ans_in) == m_total)
                    m_score <= (m_score >= SCORE_MAX) ? SCORE_MAX : m_score + 1;
                else
                    m_score <= (m_score == 0) ? 0 : m_score - 1;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("m_busy",    busy,         m_phase != 0);
        chk("m_sum",     sum_out,      m_total);
        chk("m_rv",      result_valid, m_rv);
        chk("m_correct", correct,      m_ok);
        chk("m_timeout", timed_out,    m_to);
        chk("m_score",   score,        m_score);
        chk("m_led",     led,          ((1 << m_score) - 1) & ((1 << SCORE_MAX) - 1));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        round_start = 1'b1; step(); round_start = 1'b0;
    endtask

    task automatic op(input int v);
        num_valid = 1'b1; num_in = DATA_W'(v); step(); num_valid = 1'b0;
    endtask

    task automatic answer(input int v);
        ans_valid = 1'b1; ans_in = ANS_W'(v); step(); ans_valid = 1'b0;
    endtask

    task automatic ops5(input int a, input int b, input int c, input int d, input int e);
        op(a); op(b); op(c); op(d); op(e);
    endtask

    // Full round with the standard operands (sum 32).
    task automatic std_round(input int ans);
        start(); ops5(3, 7, 12, 1, 9); answer(ans);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_score", score, 0);
        chk("rst_led", led, 0);
        chk("rst_rv", result_valid, 0);
        rst = 1'b0;
        step();

        // 1: basic correct round
        start();
        ops5(3, 7, 12, 1, 9);
        chk("t1_sum", sum_out, 32);
        chk("t1_busy", busy, 1);
        answer(32);
        chk("t1_rv", result_valid, 1);
        chk("t1_correct", correct, 1);
        chk("t1_to", timed_out, 0);
        chk("t1_score", score, 1);
        chk("t1_led", led, 7'b0000001);
        step();
        chk("t1_rv_pulse", result_valid, 0);
        chk("t1_correct_held", correct, 1);
        chk("t1_sum_held", sum_out, 32);

        // 2: wrong answers, floor at 0
        std_round(31);
        chk("t2_correct", correct, 0);
        chk("t2_score", score, 0);
        std_round(31);
        chk("t2_floor", score, 0);

        // 3: saturation at SCORE_MAX
        for (int k = 1; k <= 8; k++) begin
            std_round(32);
            if (k == 7) begin
                chk("t3_score7", score, 7);
                chk("t3_led7", led, 7'b1111111);
            end
        end
        chk("t3_sat", score, 7);

        // 4a: timeout
        start(); ops5(3, 7, 12, 1, 9);
        repeat (TIMEOUT_CYC - 1) step();
        chk("t4_still_wait", busy, 1);
        chk("t4_no_rv_yet", result_valid, 0);
        step();
        chk("t4_rv", result_valid, 1);
        chk("t4_to", timed_out, 1);
        chk("t4_correct", correct, 0);
        chk("t4_score", score, 6);
        // 4b: answer on the final window cycle
        start(); ops5(3, 7, 12, 1, 9);
        repeat (TIMEOUT_CYC - 1) step();
        answer(32);
        chk("t4b_rv", result_valid, 1);
        chk("t4b_to", timed_out, 0);
        chk("t4b_correct", correct, 1);
        chk("t4b_score", score, 7);

        // round_start beats ans_valid, then round_start beats num_valid
        start(); ops5(3, 7, 12, 1, 9);
        round_start = 1'b1; ans_valid = 1'b1; ans_in = 8'd32;
        step();
        round_start = 1'b0; ans_valid = 1'b0;
        chk("rs_ans_rv", result_valid, 0);
        chk("rs_ans_busy", busy, 1);
        chk("rs_ans_sum", sum_out, 0);
        chk("rs_ans_score", score, 7);
        op(5);
        round_start = 1'b1; num_valid = 1'b1; num_in = 5'd20;
        step();
        round_start = 1'b0; num_valid = 1'b0;
        chk("rs_num_sum", sum_out, 0);

        // 5: abort mid-round (score 6 beforehand)
        std_round(0);
        chk("t5_pre", score, 6);
        start(); op(1); op(2); op(3);
        start();
        chk("t5_abort_sum", sum_out, 0);
        chk("t5_abort_score", score, 6);
        ops5(31, 31, 31, 31, 31);
        chk("t5_sum", sum_out, 155);
        answer(155);
        chk("t5_correct", correct, 1);
        chk("t5_score", score, 7);
        step();
        chk("t5_sum_hold", sum_out, 155);

        // 6: reset during WAIT_ANS with score 4
        repeat (3) std_round(0);
        chk("t6_pre", score, 4);
        start(); ops5(3, 7, 12, 1, 9);
        step();
        rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_sum", sum_out, 0);
        chk("t6_score", score, 0);
        chk("t6_led", led, 0);
        chk("t6_rv", result_valid, 0);
        step();
        rst = 1'b0;
        answer(0);
        chk("t6_ignored_rv", result_valid, 0);
        chk("t6_ignored_score", score, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
